// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder and the control unit:
// FSM encoding, word width, opcodes and the request-rejection rule.
package mem_responder_pkg;

   localparam int WORD_W = 32;

   localparam logic [5:0] OP_ADD = 6'b000001;
   localparam logic [5:0] OP_LW  = 6'b000010;
   localparam logic [5:0] OP_SW  = 6'b000101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // A request is rejected if it asks for both operations, is not word
   // aligned, or falls at or beyond the end of storage (no wrap-around).
   function automatic logic req_rejected(input logic rd, input logic wr,
                                         input logic [WORD_W-1:0] addr,
                                         input int unsigned depth);
      logic [WORD_W-1:0] limit;
      limit = WORD_W'(depth) << 2;
      return (rd && wr) || (addr[1:0] != 2'b00) || (addr >= limit);
   endfunction

endpackage

// File: rtl/mem_responder_word_ram.sv
// Word storage: synchronous write, registered read, contents never reset.
module word_ram
   import mem_responder_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [AW-1:0]     addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts one request in IDLE, waits
// LATENCY cycles, then pulses MemReady (and MemError on rejection).
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [WORD_W-1:0] Addr,
   input  logic [WORD_W-1:0] WriteData,
   output logic [WORD_W-1:0] ReadData,
   output logic              MemReady,
   output logic              MemError,
   output logic              Busy
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [3:0] CNT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
   localparam logic       NO_WAIT  = (LATENCY == 0);

   state_t            state;
   logic [3:0]        count;
   logic              op_write;
   logic              err_reg;
   logic [AW-1:0]     idx_reg;
   logic [WORD_W-1:0] wdata_reg;
   logic              rd_valid;
   logic              ready_reg;
   logic              error_reg;

   logic              request;
   logic              req_err;
   logic              in_idle;
   logic              enter_resp;
   logic              cur_write;
   logic              cur_err;
   logic [AW-1:0]     cur_idx;
   logic [WORD_W-1:0] cur_wdata;
   logic              ram_we;
   logic              ram_re;
   logic [WORD_W-1:0] ram_q;

   assign request = MemRead | MemWrite;
   assign req_err = req_rejected(MemRead, MemWrite, Addr, DEPTH);
   assign in_idle = (state == IDLE);

   // With zero latency the access happens on the accepting edge, so the
   // storage is fed from the live inputs in IDLE and from the latches later.
   assign enter_resp = in_idle ? (request && NO_WAIT)
                               : ((state == WAIT) && (count == 4'd0));
   assign cur_write  = in_idle ? MemWrite       : op_write;
   assign cur_err    = in_idle ? req_err        : err_reg;
   assign cur_idx    = in_idle ? Addr[AW+1:2]   : idx_reg;
   assign cur_wdata  = in_idle ? WriteData      : wdata_reg;

   assign ram_we = enter_resp && !cur_err && cur_write;
   assign ram_re = enter_resp && !cur_err && !cur_write;

   word_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (Clk),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (cur_idx),
      .wdata (cur_wdata),
      .rdata (ram_q)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state     <= IDLE;
         count     <= 4'd0;
         op_write  <= 1'b0;
         err_reg   <= 1'b0;
         idx_reg   <= '0;
         wdata_reg <= '0;
         rd_valid  <= 1'b0;
         ready_reg <= 1'b0;
         error_reg <= 1'b0;
      end else begin
         ready_reg <= enter_resp;
         error_reg <= enter_resp && cur_err;
         if (ram_re) begin
            rd_valid <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (request) begin
                  op_write  <= MemWrite;
                  err_reg   <= req_err;
                  idx_reg   <= Addr[AW+1:2];
                  wdata_reg <= WriteData;
                  count     <= CNT_LOAD;
                  state     <= NO_WAIT ? RESP : WAIT;
               end
            end
            WAIT: begin
               if (count == 4'd0) begin
                  state <= RESP;
               end else begin
                  count <= count - 4'd1;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // The RAM output register has no reset; rd_valid masks it to zero
   // until the first successful read after reset.
   assign ReadData = rd_valid ? ram_q : '0;
   assign MemReady = ready_reg;
   assign MemError = error_reg;
   assign Busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder (LATENCY=2) plus a short
// zero-latency back-to-back run on a second instance.
module tb_mem_responder;

   localparam int DEPTH   = 64;
   localparam int LATENCY = 2;

   typedef struct {
      int          acc;
      bit          err;
      bit          rd;
      logic [31:0] data;
      bit          known;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        mem_read, mem_write;
   logic [31:0] addr, write_data, read_data;
   logic        ready, error, busy;

   logic        z_read, z_write;
   logic [31:0] z_addr, z_wdata, z_rdata;
   logic        z_ready, z_error, z_busy;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          acc = -1000;
   bit          mon_en = 0;
   logic [31:0] rd_model = '0;
   bit          rd_known = 1;
   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [31:0] mdl [DEPTH];
   bit          mknown [DEPTH];

   mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .Clk(clk), .Rst_n(rst_n), .MemRead(mem_read), .MemWrite(mem_write),
      .Addr(addr), .WriteData(write_data), .ReadData(read_data),
      .MemReady(ready), .MemError(error), .Busy(busy)
   );

   mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
      .Clk(clk), .Rst_n(rst_n), .MemRead(z_read), .MemWrite(z_write),
      .Addr(z_addr), .WriteData(z_wdata), .ReadData(z_rdata),
      .MemReady(z_ready), .MemError(z_error), .Busy(z_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h required %h (cycle %0d)", name, got, exp, cyc);
      end else begin
         $display("ok   %s = %h (cycle %0d)", name, got, cyc);
      end
   endtask

   // Monitor: pops an expectation whenever the DUT signals MemReady.
   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         chk("busy", 32'(busy), 32'(cyc >= acc && cyc <= acc + LATENCY));
         if (ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ready got MemReady=1 required no pending request (cycle %0d)", cyc);
            end else begin
               mon_e = exp_q.pop_front();
               chk("latency", 32'(cyc - mon_e.acc), 32'(LATENCY));
               chk("error", 32'(error), 32'(mon_e.err));
               if (mon_e.rd && !mon_e.err) begin
                  rd_model = mon_e.data;
                  rd_known = mon_e.known;
               end
            end
         end else begin
            chk("error_without_ready", 32'(error), 32'd0);
         end
         if (rd_known) chk("read_data", read_data, rd_model);
      end
   end

   // Called just after a falling edge; returns after the response cycle.
   task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      int   idx;
      mem_read = rd; mem_write = wr; addr = a; write_data = d;
      @(posedge clk);
      #1;
      acc = cyc;
      e.acc   = cyc;
      e.rd    = rd && !wr;
      e.err   = (rd && wr) || (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
      e.data  = '0;
      e.known = 0;
      if (!e.err) begin
         idx = int'(a >> 2);
         if (wr) begin
            mdl[idx] = d;
            mknown[idx] = 1;
         end else begin
            e.data  = mdl[idx];
            e.known = mknown[idx];
         end
      end
      exp_q.push_back(e);
      repeat (LATENCY + 1) begin
         @(negedge clk);
         mem_read = 1'($urandom); mem_write = 1'($urandom);
         addr = $urandom; write_data = $urandom;
         @(posedge clk);
      end
      @(negedge clk);
      mem_read = 0; mem_write = 0;
   endtask

   initial begin
      int          k, r;
      logic [31:0] a;
      for (int i = 0; i < DEPTH; i++) mknown[i] = 0;
      rst_n = 0; mem_read = 0; mem_write = 0; addr = '0; write_data = '0;
      z_read = 0; z_write = 0; z_addr = '0; z_wdata = '0;
      #1;
      chk("reset_read_data", read_data, 32'd0);
      chk("reset_ready", 32'(ready), 32'd0);
      chk("reset_error", 32'(error), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      mon_en = 1;

      issue(0, 1, 32'h10, 32'hDEADBEEF);
      issue(1, 0, 32'h10, 32'h0);
      issue(1, 1, 32'h10, 32'h01010101);
      issue(1, 0, 32'h10, 32'h0);
      issue(1, 0, 32'h13, 32'h0);
      issue(1, 0, 32'h100, 32'h0);
      issue(0, 1, 32'h100, 32'h55555555);
      issue(0, 1, 32'hFC, 32'h12345678);
      issue(1, 0, 32'hFC, 32'h0);
      issue(0, 1, 32'h20, 32'h11112222);

      for (int n = 0; n < 150; n++) begin
         k = $urandom_range(0, 9);
         r = $urandom_range(0, 9);
         a = (r < 8) ? 32'(r * 4) : 32'((54 + r) * 4);
         case (k)
            0:       issue(1, 1, a, $urandom);
            1:       issue(1'($urandom), 1'($urandom) | 1'b1, a | 32'($urandom_range(1, 3)), $urandom);
            2:       issue(1, 0, 32'(4 * DEPTH) + 32'($urandom_range(0, 3) * 4), $urandom);
            default: issue(1'(k & 1), 1'(~k & 1), a, $urandom);
         endcase
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Abort a write with reset while the access is waiting.
      mem_read = 0; mem_write = 1; addr = 32'h20; write_data = 32'hAAAA5555;
      @(posedge clk);
      #1;
      acc = -1000;
      rst_n = 0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ready", 32'(ready), 32'd0);
      chk("abort_read_data", read_data, 32'd0);
      rd_model = '0;
      rd_known = 1;
      mem_write = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      issue(1, 0, 32'h20, 32'h0);
      repeat (4) @(negedge clk);

      // Zero-latency instance: continuous requests, one access every two cycles.
      z_write = 1; z_addr = 32'h0; z_wdata = 32'hC0DE0000;
      @(negedge clk);
      chk("l0_wr0_ready", 32'(z_ready), 32'd1);
      chk("l0_wr0_busy", 32'(z_busy), 32'd1);
      z_addr = 32'h4; z_wdata = 32'hC0DE0004;
      @(negedge clk);
      chk("l0_gap_ready", 32'(z_ready), 32'd0);
      chk("l0_gap_busy", 32'(z_busy), 32'd0);
      @(negedge clk);
      chk("l0_wr1_ready", 32'(z_ready), 32'd1);
      z_write = 0; z_read = 1; z_addr = 32'h0;
      @(negedge clk);
      chk("l0_idle_busy", 32'(z_busy), 32'd0);
      @(negedge clk);
      chk("l0_rd0_ready", 32'(z_ready), 32'd1);
      chk("l0_rd0_busy", 32'(z_busy), 32'd1);
      chk("l0_rd0_data", z_rdata, 32'hC0DE0000);
      z_addr = 32'h4;
      @(negedge clk);
      chk("l0_rd_gap_ready", 32'(z_ready), 32'd0);
      chk("l0_rd_gap_busy", 32'(z_busy), 32'd0);
      @(negedge clk);
      chk("l0_rd1_ready", 32'(z_ready), 32'd1);
      chk("l0_rd1_error", 32'(z_error), 32'd0);
      chk("l0_rd1_data", z_rdata, 32'hC0DE0004);
      z_read = 0;
      @(negedge clk);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words of storage (power of two, 4..256).
REQ-002 Parameter LATENCY, default 2: wait cycles between request acceptance and response (0..15).
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 MemRead  input  1  read request from the control unit.
REQ-006 MemWrite  input  1  write request from the control unit.
REQ-007 Addr  input  32  byte address from the ALU result.
REQ-008 WriteData  input  32  store data.
REQ-009 ReadData  output  32  load data; held until the next successful read.
REQ-010 MemReady  output  1  one-cycle pulse: access complete or rejected.
REQ-011 MemError  output  1  one-cycle pulse coincident with MemReady: request rejected.
REQ-012 Busy  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-014 IDLE: a request (MemRead or MemWrite high) at a rising edge SHALL be accepted, latching op, Addr and WriteData, and moving to WAIT (or to RESP if LATENCY=0).
REQ-015 Inputs SHALL be ignored outside IDLE; the requester need not hold them after acceptance.
REQ-016 WAIT: a down-counter loaded with LATENCY-1 SHALL decrement each cycle; the transition to RESP occurs when it reaches 0.
REQ-017 RESP SHALL last exactly one cycle with MemReady=1, then return to IDLE. A request accepted at edge T gives MemReady high in cycle T+LATENCY+1.
REQ-018 A new request SHALL be accepted at the first edge after RESP (back-to-back throughput: one access per LATENCY+2 cycles).
REQ-019 Reads SHALL update ReadData at the edge that enters RESP, with mem[Addr[log2(DEPTH)+1:2]].
REQ-020 Writes SHALL commit to storage at the edge that enters RESP; ReadData SHALL be unchanged.
REQ-021 The request SHALL be rejected (MemError=1 with MemReady, no storage or ReadData change) if: MemRead and MemWrite are both high; Addr[1:0] != 0; or Addr >= 4*DEPTH.
REQ-022 A rejected request SHALL still follow the full IDLE->WAIT->RESP timing.
REQ-023 MemError SHALL be 0 in every cycle in which MemReady is 0.
REQ-024 The top word (Addr = 4*DEPTH-4) SHALL be accessible; Addr = 4*DEPTH SHALL be rejected (no wrap-around).

Reset
REQ-025 Rst_n low SHALL immediately force state IDLE, counter 0, ReadData 0, MemReady 0, MemError 0, Busy 0.
REQ-026 Reset asserted during WAIT SHALL abort the access: no write commits and no MemReady pulse follows.
REQ-027 Storage contents SHALL NOT be reset and are undefined until written.
REQ-028 After Rst_n deasserts, the first rising edge SHALL be able to accept a request.

Structure
REQ-029 The FSM state encoding, the word width (32) and the opcode constants shared with the control unit (add 6'b000001, lw 6'b000010, sw 6'b000101) SHALL reside in a shared package.
REQ-030 Storage SHALL be a sub-module word_ram (synchronous write, registered read, no reset); the FSM, counter and checking logic SHALL remain in mem_responder.

Verification
REQ-031 Reset, then write 0xDEADBEEF to Addr 0x10 and read Addr 0x10 (LATENCY=2) -> MemReady three cycles after each acceptance; ReadData=0xDEADBEEF; MemError=0.
REQ-032 MemRead and MemWrite both high, Addr 0x10 -> MemReady+MemError after 3 cycles; a following read of 0x10 still returns 0xDEADBEEF.
REQ-033 Read Addr 0x13 and read Addr 0x100 (DEPTH=64) -> both rejected; read Addr 0xFC after writing 0x12345678 there -> 0x12345678, no error.
REQ-034 Write 0xAAAA5555 to 0x20; pulse Rst_n low during WAIT -> no MemReady; Busy=0 immediately; a subsequent read of 0x20 does not return 0xAAAA5555 unless it held that value before.
REQ-035 LATENCY=0: back-to-back reads of 0x00 and 0x04 held continuously high -> MemReady in the cycles after acceptance at T and T+2; Busy low only in the IDLE cycles between.
REQ-036 Change Addr and WriteData during WAIT -> the originally latched values are used.
